// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: unsigned N x N -> 2N shift-add multiplier. It makes one pass per bit
// through an external combinational ALU that it drives in add mode.
//
// Build option: define MUL_ZERO_BYPASS_EN to skip the iteration loop when either operand
// is zero. In that case the sequencer goes straight from IDLE to DONE with a zero product.
//
// Handshake: start is sampled only in IDLE. busy is high in RUN and DONE. done pulses for
// one cycle, and product holds the result in that same cycle. Reset is synchronous and
// active-high.

module alu_mul_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product,
  output logic [1:0]       alu_m,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_r,
  input  logic             alu_c
);

  // Iteration counter width, derived from N.
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   product_q, product_d;

  // State and datapath registers. A synchronous reset clears everything, so a reset
  // mid-RUN discards the partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_hi_q  <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update. In RUN, each cycle shifts the (N+1)-bit ALU sum right
  // into {acc_hi, mq}, and the multiplier bit just consumed falls off the bottom.
  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = op_a;
          mq_d     = op_b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = StRun;
`ifdef MUL_ZERO_BYPASS_EN
          // A zero operand gives a zero product, so the iteration loop is skipped.
          if ((op_a == '0) || (op_b == '0)) begin
            mq_d    = '0;
            state_d = StDone;
          end
`endif
        end
      end

      StRun: begin
        {acc_hi_d, mq_d} = {alu_c, alu_r, mq_q[N-1:1]};
        count_d          = count_q + CW'(1);
        if (count_q == LastIter) begin
          state_d = StDone;
        end
      end

      StDone: begin
        product_d = {acc_hi_q, mq_q};
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and ALU drive. The product register only loads at the end of DONE, so the
  // live accumulator is forwarded during DONE to make product valid alongside done.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    product = (state_q == StDone) ? {acc_hi_q, mq_q} : product_q;
    alu_m   = 2'b00;
    alu_a   = acc_hi_q;
    alu_b   = mq_q[0] ? mcand_q : '0;
  end

endmodule
